// File: rtl/barrel_thread_ctl.sv
// rtl/barrel_thread_ctl.sv - per-thread context store and round-robin issue scheduler
// Optional feature: BARREL_THREAD_CTL_RESUME_EN adds resume_req/resume_tid to clear halt bits.
module barrel_thread_ctl #(
    parameter int NTHREADS = 2,
    parameter int PC_W     = 16,
    parameter int SP_W     = 8,
    localparam int TID_W   = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_hold,
    output logic             issue_valid,
    output logic [TID_W-1:0] issue_tid,
    output logic [PC_W-1:0]  issue_pc,
    output logic [SP_W-1:0]  issue_sp,
    output logic [3:0]       issue_pre,
    output logic             issue_preset,
    output logic             issue_torf,
    input  logic             pc_we,
    input  logic [TID_W-1:0] pc_tid,
    input  logic [PC_W-1:0]  pc_wdata,
    input  logic             sp_we,
    input  logic [TID_W-1:0] sp_tid,
    input  logic [SP_W-1:0]  sp_wdata,
    input  logic             pre_we,
    input  logic             pre_clr,
    input  logic [TID_W-1:0] pre_tid,
    input  logic [3:0]       pre_wdata,
    input  logic             torf_we,
    input  logic [TID_W-1:0] torf_tid,
    input  logic             torf_wdata,
    input  logic             halt_req,
    input  logic [TID_W-1:0] halt_tid,
`ifdef BARREL_THREAD_CTL_RESUME_EN
    input  logic             resume_req,
    input  logic [TID_W-1:0] resume_tid,
`endif
    output logic             all_halted
);

    logic [PC_W-1:0]     pc   [NTHREADS];
    logic [SP_W-1:0]     sp   [NTHREADS];
    logic [3:0]          pre  [NTHREADS];
    logic [NTHREADS-1:0] preset;
    logic [NTHREADS-1:0] torf;
    logic [NTHREADS-1:0] halt;
    logic [NTHREADS-1:0] halt_next;
    logic [TID_W-1:0]    next_tid;
    logic [TID_W-1:0]    cand;
    logic                found;

    // Halt wins over resume on the same thread in the same cycle.
    always_comb begin
        halt_next = halt;
`ifdef BARREL_THREAD_CTL_RESUME_EN
        if (resume_req) halt_next[resume_tid] = 1'b0;
`endif
        if (halt_req) halt_next[halt_tid] = 1'b1;
    end

    // Search starts after issue_tid; wrapping index NTHREADS lands back on issue_tid itself.
    always_comb begin
        next_tid = issue_tid;
        cand     = issue_tid;
        found    = 1'b0;
        if (issue_hold && !halt_next[issue_tid]) begin
            found = 1'b1;
        end else begin
            for (int i = 1; i <= NTHREADS; i++) begin
                cand = issue_tid + TID_W'(i);
                if (!found && !halt_next[cand]) begin
                    next_tid = cand;
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_tid <= '0;
            halt      <= '0;
            preset    <= '0;
            torf      <= '0;
            for (int t = 0; t < NTHREADS; t++) begin
                pc[t]  <= PC_W'(t) << (PC_W - TID_W);
                sp[t]  <= '0;
                pre[t] <= '0;
            end
        end else begin
            issue_tid <= next_tid;
            halt      <= halt_next;
            if (pc_we) pc[pc_tid] <= pc_wdata;
            if (sp_we) sp[sp_tid] <= sp_wdata;
            if (pre_we) begin
                pre[pre_tid]    <= pre_wdata;
                preset[pre_tid] <= 1'b1;
            end else if (pre_clr) begin
                preset[pre_tid] <= 1'b0;
            end
            if (torf_we) torf[torf_tid] <= torf_wdata;
        end
    end

    assign issue_valid  = ~halt[issue_tid];
    assign issue_pc     = pc[issue_tid];
    assign issue_sp     = sp[issue_tid];
    assign issue_pre    = pre[issue_tid];
    assign issue_preset = preset[issue_tid];
    assign issue_torf   = torf[issue_tid];
    assign all_halted   = &halt;

endmodule

// File: tb/tb_barrel_thread_ctl.sv
// tb/tb_barrel_thread_ctl.sv - directed scoreboard bench for barrel_thread_ctl with NTHREADS=4
module tb_barrel_thread_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_hold;
    logic        issue_valid;
    logic [1:0]  issue_tid;
    logic [15:0] issue_pc;
    logic [7:0]  issue_sp;
    logic [3:0]  issue_pre;
    logic        issue_preset;
    logic        issue_torf;
    logic        pc_we, sp_we, pre_we, pre_clr, torf_we, halt_req;
    logic [1:0]  pc_tid, sp_tid, pre_tid, torf_tid, halt_tid;
    logic [15:0] pc_wdata;
    logic [7:0]  sp_wdata;
    logic [3:0]  pre_wdata;
    logic        torf_wdata;
    logic        all_halted;
`ifdef BARREL_THREAD_CTL_RESUME_EN
    logic        resume_req;
    logic [1:0]  resume_tid;
`endif

    barrel_thread_ctl #(.NTHREADS(4), .PC_W(16), .SP_W(8)) dut (
        .clk(clk), .reset(reset), .issue_hold(issue_hold),
        .issue_valid(issue_valid), .issue_tid(issue_tid), .issue_pc(issue_pc),
        .issue_sp(issue_sp), .issue_pre(issue_pre), .issue_preset(issue_preset),
        .issue_torf(issue_torf),
        .pc_we(pc_we), .pc_tid(pc_tid), .pc_wdata(pc_wdata),
        .sp_we(sp_we), .sp_tid(sp_tid), .sp_wdata(sp_wdata),
        .pre_we(pre_we), .pre_clr(pre_clr), .pre_tid(pre_tid), .pre_wdata(pre_wdata),
        .torf_we(torf_we), .torf_tid(torf_tid), .torf_wdata(torf_wdata),
        .halt_req(halt_req), .halt_tid(halt_tid),
`ifdef BARREL_THREAD_CTL_RESUME_EN
        .resume_req(resume_req), .resume_tid(resume_tid),
`endif
        .all_halted(all_halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  tid;
        logic        valid;
        logic [15:0] pc;
        logic [7:0]  sp;
        logic [3:0]  pre;
        logic        preset;
        logic        torf;
        logic        allh;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   stepn = 0;

    task automatic push_exp(input logic [1:0] tid, input logic v, input logic [15:0] pc,
                            input logic [7:0] sp, input logic [3:0] pre, input logic ps,
                            input logic tf, input logic ah);
        exp_t e;
        e = '{tid: tid, valid: v, pc: pc, sp: sp, pre: pre, preset: ps, torf: tf, allh: ah};
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL step%0d %s: got %0h expected %0h", stepn, name, got, want);
        end
    endtask

    task automatic check_out();
        exp_t e;
        stepn++;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL step%0d scoreboard: got empty queue expected an entry", stepn);
        end else begin
            e = sb.pop_front();
            cmp("issue_tid",    32'(issue_tid),    32'(e.tid));
            cmp("issue_valid",  32'(issue_valid),  32'(e.valid));
            cmp("issue_pc",     32'(issue_pc),     32'(e.pc));
            cmp("issue_sp",     32'(issue_sp),     32'(e.sp));
            cmp("issue_pre",    32'(issue_pre),    32'(e.pre));
            cmp("issue_preset", 32'(issue_preset), 32'(e.preset));
            cmp("issue_torf",   32'(issue_torf),   32'(e.torf));
            cmp("all_halted",   32'(all_halted),   32'(e.allh));
        end
    endtask

    task automatic go(input logic [1:0] tid, input logic v, input logic [15:0] pc,
                      input logic [7:0] sp, input logic [3:0] pre, input logic ps,
                      input logic tf, input logic ah);
        push_exp(tid, v, pc, sp, pre, ps, tf, ah);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic clr();
        pc_we = 0; sp_we = 0; pre_we = 0; pre_clr = 0; torf_we = 0; halt_req = 0;
        pc_tid = 0; sp_tid = 0; pre_tid = 0; torf_tid = 0; halt_tid = 0;
        pc_wdata = 0; sp_wdata = 0; pre_wdata = 0; torf_wdata = 0;
`ifdef BARREL_THREAD_CTL_RESUME_EN
        resume_req = 0; resume_tid = 0;
`endif
    endtask

    initial begin
        reset = 1'b1;
        issue_hold = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        push_exp(2'd0, 1, 16'h0000, 8'h00, 4'h0, 0, 0, 0);
        check_out();

        // Plain rotation and reset PCs
        go(2'd1, 1, 16'h4000, 8'h00, 4'h0, 0, 0, 0);
        go(2'd2, 1, 16'h8000, 8'h00, 4'h0, 0, 0, 0);
        go(2'd3, 1, 16'hC000, 8'h00, 4'h0, 0, 0, 0);
        go(2'd0, 1, 16'h0000, 8'h00, 4'h0, 0, 0, 0);
        go(2'd1, 1, 16'h4000, 8'h00, 4'h0, 0, 0, 0);

        // Halt thread 2 while thread 1 is issued: skipped by the same edge
        halt_req = 1; halt_tid = 2'd2;
        go(2'd3, 1, 16'hC000, 8'h00, 4'h0, 0, 0, 0);
        clr();
        go(2'd0, 1, 16'h0000, 8'h00, 4'h0, 0, 0, 0);
        go(2'd1, 1, 16'h4000, 8'h00, 4'h0, 0, 0, 0);

        // PC/SP write-back to thread 1, visible next time it issues
        pc_we = 1; pc_tid = 2'd1; pc_wdata = 16'hFFFF;
        sp_we = 1; sp_tid = 2'd1; sp_wdata = 8'hFF;
        go(2'd3, 1, 16'hC000, 8'h00, 4'h0, 0, 0, 0);
        clr();
        go(2'd0, 1, 16'h0000, 8'h00, 4'h0, 0, 0, 0);
        go(2'd1, 1, 16'hFFFF, 8'hFF, 4'h0, 0, 0, 0);

        // Hold on thread 1 while writing its context; SP wraps to 0x00
        issue_hold = 1;
        pc_we = 1; pc_tid = 2'd1; pc_wdata = 16'h1234;
        sp_we = 1; sp_tid = 2'd1; sp_wdata = 8'h00;
        pre_we = 1; pre_tid = 2'd1; pre_wdata = 4'hA;
        torf_we = 1; torf_tid = 2'd1; torf_wdata = 1;
        go(2'd1, 1, 16'h1234, 8'h00, 4'hA, 1, 1, 0);
        clr();
        pre_we = 1; pre_clr = 1; pre_tid = 2'd1; pre_wdata = 4'h5;
        go(2'd1, 1, 16'h1234, 8'h00, 4'h5, 1, 1, 0);
        clr();
        pre_clr = 1; pre_tid = 2'd1;
        go(2'd1, 1, 16'h1234, 8'h00, 4'h5, 0, 1, 0);
        clr();

        // Halting the held thread overrides hold
        halt_req = 1; halt_tid = 2'd1;
        go(2'd3, 1, 16'hC000, 8'h00, 4'h0, 0, 0, 0);
        clr();
        issue_hold = 0;
        go(2'd0, 1, 16'h0000, 8'h00, 4'h0, 0, 0, 0);
        go(2'd3, 1, 16'hC000, 8'h00, 4'h0, 0, 0, 0);
        halt_req = 1; halt_tid = 2'd3;
        go(2'd0, 1, 16'h0000, 8'h00, 4'h0, 0, 0, 0);
        clr();
        go(2'd0, 1, 16'h0000, 8'h00, 4'h0, 0, 0, 0);

        // Last live thread halts: all_halted one cycle later, pointer holds
        halt_req = 1; halt_tid = 2'd0;
        go(2'd0, 0, 16'h0000, 8'h00, 4'h0, 0, 0, 1);
        clr();
        pc_we = 1; pc_tid = 2'd0; pc_wdata = 16'h0042;
        go(2'd0, 0, 16'h0042, 8'h00, 4'h0, 0, 0, 1);
        clr();

`ifdef BARREL_THREAD_CTL_RESUME_EN
        resume_req = 1; resume_tid = 2'd3;
        go(2'd3, 1, 16'hC000, 8'h00, 4'h0, 0, 0, 0);
        clr();
        halt_req = 1; halt_tid = 2'd3; resume_req = 1; resume_tid = 2'd3;
        go(2'd3, 0, 16'hC000, 8'h00, 4'h0, 0, 0, 1);
        go(2'd3, 0, 16'hC000, 8'h00, 4'h0, 0, 0, 1);
        clr();
`endif

        // Asynchronous reset mid-operation discards the pending write
        #2;
        pc_we = 1; pc_tid = 2'd0; pc_wdata = 16'h5555;
        reset = 1'b1;
        #1;
        push_exp(2'd0, 1, 16'h0000, 8'h00, 4'h0, 0, 0, 0);
        check_out();
        #1;
        reset = 1'b0;
        clr();
        go(2'd1, 1, 16'h4000, 8'h00, 4'h0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
